// File: rtl/systolic_result_collector_pkg.sv
// Shared constants and types for the systolic array result collector.
// Array geometry, collector FSM states and a saturating counter helper.
package systolic_result_collector_pkg;

  localparam int SA_N          = 5;
  localparam int SA_DW         = 16;
  localparam int SA_ARRAY_LAT  = 5;
  localparam int SA_NUM_VEC    = 5;
  localparam int SA_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2
  } coll_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/systolic_result_collector_fifo.sv
// Result FIFO: extra-bit pointers for full/empty, registered head output.
// A write into a full FIFO is taken only when a pop happens that cycle.
module collector_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      rptr_n;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = !empty && rd_ready;
  assign push    = wr_en && (!full || pop);
  assign wr_drop = wr_en && full && !pop;
  assign rptr_n  = pop ? rptr + (AW+1)'(1) : rptr;

  assign rd_valid = !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Head keeps its last value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      rptr <= rptr_n;
      if (push && (rptr_n == wptr))
        rd_data <= wr_data;
      else if (rptr_n != wptr)
        rd_data <= mem[rptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// De-skews column-staggered array outputs and queues whole result vectors.
// Optional saturating drop counter: define COLLECT_DROP_CNT_EN.
module systolic_result_collector
  import systolic_result_collector_pkg::*;
#(
  parameter int N          = SA_N,
  parameter int DW         = SA_DW,
  parameter int ARRAY_LAT  = SA_ARRAY_LAT,
  parameter int NUM_VEC    = SA_NUM_VEC,
  parameter int FIFO_DEPTH = SA_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            start,
  input  logic [N*DW-1:0] col_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N*DW-1:0] res_data,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  localparam int VW = N * DW;

  logic [VW-1:0] aligned;
  coll_state_e   state_q;
  logic [7:0]    cnt_q;
  logic [7:0]    k_q;
  logic          accept;
  logic          capture;
  logic          last;
  logic          wr_drop;

  // Column c waits N-1-c ticks so all columns line up with column N-1.
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int L = N - 1 - c;
    if (L == 0) begin : g_thru
      assign aligned[c*DW +: DW] = col_in[c*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] pipe [L];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else if (ena) begin
          pipe[0] <= col_in[c*DW +: DW];
          for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign aligned[c*DW +: DW] = pipe[L-1];
    end
  end

  assign accept  = ena && start && (state_q == ST_IDLE);
  assign capture = ena && (state_q == ST_CAPT);
  assign last    = capture && (k_q == 8'(NUM_VEC - 1));
  assign busy    = (state_q != ST_IDLE);
  assign done    = rst_n && last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
    end else if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WAIT;
            cnt_q   <= 8'(ARRAY_LAT + N - 2);
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_q <= ST_CAPT;
            k_q     <= '0;
          end
        end
        ST_CAPT: begin
          k_q <= k_q + 8'd1;
          if (k_q == 8'(NUM_VEC - 1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (accept)  overflow <= 1'b0;
    else if (wr_drop) overflow <= 1'b1;
  end

`ifdef COLLECT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       drop_cnt <= '0;
    else if (accept)  drop_cnt <= '0;
    else if (wr_drop) drop_cnt <= sat_inc8(drop_cnt);
  end
`else
  assign drop_cnt = '0;
`endif

  collector_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (capture),
    .wr_data  (aligned),
    .rd_ready (res_ready),
    .rd_valid (res_valid),
    .rd_data  (res_data),
    .wr_drop  (wr_drop)
  );

endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench for systolic_result_collector: directed batches plus random traffic
// checked every cycle against a tick-indexed queue model of the collector.
module tb_systolic_result_collector;
  import systolic_result_collector_pkg::*;

  localparam int N     = SA_N;
  localparam int DW    = SA_DW;
  localparam int LAT   = SA_ARRAY_LAT;
  localparam int NV    = SA_NUM_VEC;
  localparam int DEPTH = SA_FIFO_DEPTH;
  localparam int VW    = N * DW;
  localparam int ALIGN = LAT + N - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic [VW-1:0] col_in = '0;
  logic          res_valid;
  logic [VW-1:0] res_data;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  systolic_result_collector #(
    .N          (N),
    .DW         (DW),
    .ARRAY_LAT  (LAT),
    .NUM_VEC    (NV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .col_in    (col_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Model: batch progress in ticks since start, plus a plain vector queue.
  logic [VW-1:0] mq [$];
  logic [VW-1:0] m_head = '0;
  bit            m_busy = 0;
  int            m_t = 0;
  bit            m_ovf = 0;
  int            m_drop = 0;
  bit            directed = 0;
  logic [DW-1:0] vtab [NV][N];

  function automatic logic [VW-1:0] vec_of(input int k);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = vtab[k][c];
    return v;
  endfunction

  task automatic new_batch();
    for (int k = 0; k < NV; k++)
      for (int c = 0; c < N; c++)
        vtab[k][c] = directed ? DW'(16'h0100 * (c + 1) + k)
                              : DW'($urandom);
  endtask

  task automatic cyc(input bit r, input bit e, input bit s, input bit rd);
    int            cur;
    int            j;
    int            k;
    bit            was_full;
    bit            pop;
    logic [VW-1:0] exp_d;
    @(negedge clk);
    rst_n     = r;
    ena       = e;
    start     = s;
    res_ready = rd;
    cur = m_t + 1;
    k   = cur - ALIGN;
    for (int c = 0; c < N; c++) begin
      j = cur - LAT - c;
      if (m_busy && e && j >= 0 && j < NV)
        col_in[c*DW +: DW] = vtab[j][c];
      else
        col_in[c*DW +: DW] = DW'($urandom);
    end
    #1;
    exp_d = (mq.size() > 0) ? mq[0] : m_head;
    check("res_valid", VW'(res_valid), VW'(mq.size() > 0));
    check("res_data", res_data, exp_d);
    check("busy", VW'(busy), VW'(m_busy));
    check("done", VW'(done), VW'(r && e && m_busy && k == NV - 1));
    check("overflow", VW'(overflow), VW'(m_ovf));
    check("drop_cnt", VW'(drop_cnt), VW'(m_drop));
    if (!r) begin
      mq.delete();
      m_head = '0;
      m_busy = 0;
      m_t    = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      was_full = (mq.size() >= DEPTH);
      pop      = (mq.size() > 0) && rd;
      if (pop) void'(mq.pop_front());
      if (m_busy && e && k >= 0 && k < NV) begin
        if (!was_full || pop) begin
          mq.push_back(vec_of(k));
        end else begin
          m_ovf = 1;
`ifdef COLLECT_DROP_CNT_EN
          if (m_drop < 255) m_drop++;
`endif
        end
      end
      if (mq.size() > 0) m_head = mq[0];
      if (m_busy && e) begin
        if (k == NV - 1) m_busy = 0;
        else m_t = cur;
      end else if (!m_busy && e && s) begin
        m_busy = 1;
        m_t    = 0;
        m_ovf  = 0;
        m_drop = 0;
        new_batch();
      end
    end
  endtask

  task automatic run(input int n, input bit e, input bit s, input bit rd);
    for (int i = 0; i < n; i++) cyc(1'b1, e, s, rd);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));

    directed = 1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    run(16, 1'b1, 1'b0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    run(4, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b1);
    run(6, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b1);
    run(10, 1'b1, 1'b0, 1'b1);

    directed = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    run(18, 1'b1, 1'b0, 1'b0);
    run(8, 1'b1, 1'b0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    run(12, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    run(8, 1'b1, 1'b0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    run(10, 1'b1, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    run(5, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 99) != 0,
          $urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
